// File: rtl/pe_pkg.sv
// Shared constants and helpers for the systolic MAC processing element.
package pe_pkg;

  localparam int unsigned PE_INT  = 0;
  localparam int unsigned PE_FP32 = 1;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // Working width for clipping an accumulator to the result width.
  localparam int unsigned SAT_W = 128;

  // Returns {clipped, value}: value is sum limited to the signed dw-bit range.
  function automatic logic [SAT_W:0] sat_to_dw(input logic signed [SAT_W-1:0] sum,
                                               input int unsigned dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (sum > hi) return {1'b1, hi};
    if (sum < lo) return {1'b1, lo};
    return {1'b0, sum};
  endfunction

endpackage

// File: rtl/pe_arith.sv
// Combinational multiplier and adder, signed integer or FP32 depending on FLOAT_MODE.
module pe_arith
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLOAT_MODE = 1,
  parameter int unsigned PW         = 32
) (
  input  logic [DATA_WIDTH-1:0] mul_a,
  input  logic [DATA_WIDTH-1:0] mul_b,
  output logic [PW-1:0]         mul_p,
  input  logic [PW-1:0]         add_a,
  input  logic [PW-1:0]         add_b,
  output logic [PW-1:0]         add_s
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  // FP32 multiply: denormals flush to zero, round to nearest even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic signed [10:0] e;
    logic [22:0]       f;
    logic              g;
    logic              st;
    logic [30:0]       r;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = 11'(a[30:23]) + 11'(b[30:23]) - 11'sd127;
    if (p[47]) begin
      f  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 11'sd1;
    end else begin
      f  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 11'sd0) return {s, 31'd0};
    // Carry out of the fraction rolls into the exponent field.
    r = {e[7:0], f} + 31'(g & (st | f[0]));
    return {s, r};
  endfunction

  // FP32 add: align with guard/round/sticky, normalise, round to nearest even.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x;
    logic [31:0]        y;
    logic [7:0]         d;
    logic [26:0]        mx;
    logic [26:0]        my;
    logic [26:0]        mask;
    logic [27:0]        n;
    logic signed [10:0] e;
    logic [4:0]         lz;
    logic               found;
    logic [22:0]        f;
    logic               g;
    logic               st;
    logic [30:0]        r;
    if (b[30:23] == 8'd0) return (a[30:23] == 8'd0) ? 32'd0 : a;
    if (a[30:23] == 8'd0) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      my = 27'd1;
    end else begin
      mask = ~(27'h7FF_FFFF << d);
      st   = |(my & mask);
      my   = (my >> d) | 27'(st);
    end
    if (x[31] == y[31]) n = {1'b0, mx} + {1'b0, my};
    else                n = {1'b0, mx} - {1'b0, my};
    if (n == 28'd0) return 32'd0;
    e = 11'(x[30:23]);
    if (n[27]) begin
      n = (n >> 1) | 28'(n[0]);
      e = e + 11'sd1;
    end else begin
      found = 1'b0;
      lz    = 5'd0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (n[i]) found = 1'b1;
          else      lz = lz + 5'd1;
        end
      end
      n = n << lz;
      e = e - 11'(lz);
    end
    f  = n[25:3];
    g  = n[2];
    st = |n[1:0];
    if (e >= 11'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 11'sd0) return {x[31], 31'd0};
    r = {e[7:0], f} + 31'(g & (st | f[0]));
    return {x[31], r};
  endfunction

  if (FLOAT_MODE == PE_FP32) begin : g_fp
    always_comb begin
      mul_p = PW'(fp_mul(32'(mul_a), 32'(mul_b)));
      add_s = PW'(fp_add(32'(add_a), 32'(add_b)));
    end
  end else begin : g_int
    logic signed [PROD_W-1:0] p2;
    always_comb begin
      p2    = PROD_W'($signed(mul_a)) * PROD_W'($signed(mul_b));
      mul_p = PW'(p2);
      add_s = add_a + add_b;
    end
  end

endmodule

// File: rtl/pe_systolic_mac.sv
// Systolic MAC PE: forwards A east / B south and emits one result per k_len valid products.
module pe_systolic_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLOAT_MODE = 1,
  parameter int unsigned ACC_WIDTH  = 72,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [CNT_WIDTH-1:0]  cfg_k_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  fwd_valid,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  c_valid,
  output logic [DATA_WIDTH-1:0] c_out,
  output logic                  c_sat
);

  localparam int unsigned PW  = (FLOAT_MODE == PE_FP32) ? DATA_WIDTH : ACC_WIDTH;
  localparam int unsigned CW1 = CNT_WIDTH + 1;

  logic [PW-1:0]         prod;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         mul_p;
  logic [PW-1:0]         add_a;
  logic [PW-1:0]         sum;
  logic                  p_valid;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  k_lat;
  logic [CNT_WIDTH-1:0]  k_cfg;
  logic [CNT_WIDTH-1:0]  k_eff;
  logic                  first;
  logic                  last;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_sat;

  pe_arith #(
    .DATA_WIDTH (DATA_WIDTH),
    .FLOAT_MODE (FLOAT_MODE),
    .PW         (PW)
  ) u_arith (
    .mul_a (a_out),
    .mul_b (b_out),
    .mul_p (mul_p),
    .add_a (add_a),
    .add_b (prod),
    .add_s (sum)
  );

  // Group length is latched on the first product; k_len of 0 counts as 1.
  always_comb begin
    first = (cnt == '0);
    k_cfg = (cfg_k_len == '0) ? CNT_WIDTH'(1) : cfg_k_len;
    k_eff = first ? k_cfg : k_lat;
    last  = (({1'b0, cnt} + CW1'(1)) == {1'b0, k_eff});
    add_a = first ? ((FLOAT_MODE == PE_FP32) ? PW'(FP32_ZERO) : '0) : acc;
  end

  if (FLOAT_MODE == PE_FP32) begin : g_fp_res
    assign res     = DATA_WIDTH'(sum);
    assign res_sat = 1'b0;
  end else begin : g_int_res
    logic [SAT_W:0] sat_r;
    assign sat_r   = sat_to_dw(SAT_W'($signed(sum)), DATA_WIDTH);
    assign res     = DATA_WIDTH'(sat_r);
    assign res_sat = sat_r[SAT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      prod      <= '0;
      p_valid   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      k_lat     <= '0;
      c_valid   <= 1'b0;
      c_out     <= '0;
      c_sat     <= 1'b0;
    end else if (en) begin
      // Forwarding keeps running through clr so neighbours stay in lockstep.
      fwd_valid <= in_valid;
      a_out     <= in_a;
      b_out     <= in_b;
      prod      <= mul_p;
      if (clr) begin
        p_valid <= 1'b0;
        cnt     <= '0;
        acc     <= '0;
        c_valid <= 1'b0;
      end else begin
        p_valid <= fwd_valid;
        if (p_valid) begin
          if (first) k_lat <= k_cfg;
          if (last) begin
            c_out   <= res;
            c_sat   <= res_sat;
            c_valid <= 1'b1;
            cnt     <= '0;
          end else begin
            acc     <= sum;
            c_valid <= 1'b0;
            cnt     <= cnt + CNT_WIDTH'(1);
          end
        end else begin
          c_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_systolic_mac.sv
// Directed-vector bench for pe_systolic_mac: int instance plus an FP32 instance.
module tb_pe_systolic_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [7:0]  cfg_k_len;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        fv_i, cv_i, cs_i;
  logic [31:0] ao_i, bo_i, co_i;
  logic        fv_f, cv_f, cs_f;
  logic [31:0] ao_f, bo_f, co_f;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_systolic_mac #(.DATA_WIDTH(32), .FLOAT_MODE(0), .ACC_WIDTH(72), .CNT_WIDTH(8)) dut_i (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_k_len(cfg_k_len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .fwd_valid(fv_i), .a_out(ao_i), .b_out(bo_i),
    .c_valid(cv_i), .c_out(co_i), .c_sat(cs_i)
  );

  pe_systolic_mac #(.DATA_WIDTH(32), .FLOAT_MODE(1), .ACC_WIDTH(72), .CNT_WIDTH(8)) dut_f (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_k_len(cfg_k_len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .fwd_valid(fv_f), .a_out(ao_f), .b_out(bo_f),
    .c_valid(cv_f), .c_out(co_f), .c_sat(cs_f)
  );

  // k is the group length seen by the beat's first product; l marks the group's last beat.
  typedef struct {
    logic [7:0]  k;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic        l;
    logic [31:0] c;
    logic        s;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [7:0] k, input logic v, input logic [31:0] a,
                              input logic [31:0] b, input logic l, input logic [31:0] c,
                              input logic s);
    vec_t r;
    r.k = k; r.v = v; r.a = a; r.b = b; r.l = l; r.c = c; r.s = s;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; cfg_k_len = 8'd0;
    drive(1'b0, 32'd0, 32'd0);

    tv.push_back(mk(8'd3, 1'b1, 32'd2,        32'd3,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd1, 1'b1, 32'd4,        32'd5,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd1, 1'b1, 32'hFFFFFFFF, 32'd6,        1'b1, 32'd20,       1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'd1,        32'd1,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'd2,        32'd2,        1'b1, 32'd5,        1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'd3,        32'd3,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'd4,        32'd4,        1'b1, 32'd25,       1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1));
    tv.push_back(mk(8'd2, 1'b1, 32'h80000000, 32'd1,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd2, 1'b1, 32'h80000000, 32'd1,        1'b1, 32'h80000000, 1'b1));
    tv.push_back(mk(8'd0, 1'b1, 32'd5,        32'hFFFFFFFD, 1'b1, 32'hFFFFFFF1, 1'b0));
    tv.push_back(mk(8'd0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 32'd16,       1'b0));
    tv.push_back(mk(8'd3, 1'b1, 32'd1,        32'd2,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd7, 1'b1, 32'd3,        32'd4,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd0, 1'b1, 32'd5,        32'd6,        1'b1, 32'd44,       1'b0));
    tv.push_back(mk(8'd1, 1'b1, 32'hFFFFFFF9, 32'd8,        1'b1, 32'hFFFFFFC8, 1'b0));
    tv.push_back(mk(8'd0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0));
    tv.push_back(mk(8'd0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0));

    // Reset state
    step(); step();
    chk("rst c_valid", 32'(cv_i), 32'd0);
    chk("rst c_out",   co_i,      32'd0);
    chk("rst c_sat",   32'(cs_i), 32'd0);
    chk("rst a_out",   ao_i,      32'd0);
    chk("rst fwd",     32'(fv_i), 32'd0);
    chk("rst f c_out", co_f,      32'd0);

    // Build a partial group (cnt=2), then reset it away
    rst = 1'b0; cfg_k_len = 8'd3;
    drive(1'b1, 32'd9, 32'd9); step(); step();
    drive(1'b0, 32'd0, 32'd0); step(); step();
    chk("mid pre-rst c_valid", 32'(cv_i), 32'd0);
    rst = 1'b1; step();
    chk("mid rst c_valid", 32'(cv_i), 32'd0);
    chk("mid rst a_out",   ao_i,      32'd0);
    rst = 1'b0;

    // Table: beat i sampled at edge i, result checked two edges later
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].a, tv[i].b);
      cfg_k_len = (i >= 2) ? tv[i-2].k : 8'd0;
      step();
      chk($sformatf("r%0d a_out", i), ao_i, tv[i].a);
      chk($sformatf("r%0d b_out", i), bo_i, tv[i].b);
      chk($sformatf("r%0d fwd_valid", i), 32'(fv_i), 32'(tv[i].v));
      if (i >= 2) begin
        chk($sformatf("r%0d c_valid", i), 32'(cv_i), 32'(tv[i-2].l));
        if (tv[i-2].l) begin
          chk($sformatf("r%0d c_out", i), co_i, tv[i-2].c);
          chk($sformatf("r%0d c_sat", i), 32'(cs_i), 32'(tv[i-2].s));
        end
      end else begin
        chk($sformatf("r%0d c_valid", i), 32'(cv_i), 32'd0);
      end
    end

    // Freeze mid-group, then clr, then a fresh single-beat group
    cfg_k_len = 8'd3;
    drive(1'b1, 32'd1, 32'd1); step();
    drive(1'b1, 32'd2, 32'd2); step();
    en = 1'b0;
    drive(1'b1, 32'd99, 32'd99);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("frz%0d a_out", j), ao_i, 32'd2);
      chk($sformatf("frz%0d fwd", j),   32'(fv_i), 32'd1);
      chk($sformatf("frz%0d c_valid", j), 32'(cv_i), 32'd0);
    end
    en = 1'b1; clr = 1'b1;
    drive(1'b0, 32'd0, 32'd0); step();
    chk("clr c_valid", 32'(cv_i), 32'd0);
    chk("clr a_out",   ao_i,      32'd0);
    clr = 1'b0; cfg_k_len = 8'd1;
    drive(1'b1, 32'd7, 32'd7); step();
    chk("post-clr e0 c_valid", 32'(cv_i), 32'd0);
    drive(1'b0, 32'd0, 32'd0); step();
    chk("post-clr e1 c_valid", 32'(cv_i), 32'd0);
    step();
    chk("post-clr c_valid", 32'(cv_i), 32'd1);
    chk("post-clr c_out",   co_i,      32'd49);
    en = 1'b0; step();
    chk("hold c_valid", 32'(cv_i), 32'd1);
    chk("hold c_out",   co_i,      32'd49);
    en = 1'b1; step();
    chk("pulse end c_valid", 32'(cv_i), 32'd0);

    // FP32: 1.5*2.0 + 0.25*4.0 = 4.0
    cfg_k_len = 8'd2;
    drive(1'b1, 32'h3FC00000, 32'h40000000); step();
    drive(1'b1, 32'h3E800000, 32'h40800000); step();
    chk("fp a_out", ao_f, 32'h3E800000);
    drive(1'b0, 32'd0, 32'd0); step();
    chk("fp early c_valid", 32'(cv_f), 32'd0);
    step();
    chk("fp c_valid", 32'(cv_f), 32'd1);
    chk("fp c_out",   co_f,      32'h40800000);
    chk("fp c_sat",   32'(cs_f), 32'd0);
    step();
    chk("fp pulse end", 32'(cv_f), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
